s_seg_scan: RTL and testbench

- Parametrised, time-multiplexed driver for a DIGITS-wide common-anode seven-segment bank; successor to the single-digit combinational hex decoder.
- Latches a packed hex value on a load strobe and scans the digits one at a time at a prescaled refresh rate.
- Supports per-digit decimal points, leading-zero suppression and per-digit blinking.
- Sits between the processor debug/status outputs (PC, register taps) and the board display pins.

---
 rtl/s_seg_pkg.sv | 19 +
 rtl/s_seg_scan_glyph.sv | 11 +
 rtl/s_seg_scan.sv | 141 ++++++++++++++
 tb/tb_s_seg_scan.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/s_seg_pkg.sv
// Shared constants for the seven-segment scanner: glyph table, blank pattern
// and counter-width helper.
package s_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int cnt_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/s_seg_scan_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_glyph
    import s_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = GLYPH_TBL[nib_i];

endmodule

// File: rtl/s_seg_scan.sv
// Time-multiplexed seven-segment driver: prescaled digit scan with shadowed
// value/dp, leading-zero suppression and per-digit blinking.
module s_seg_scan
    import s_seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [DIGITS-1:0]     blink_en,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int IW = cnt_bits(DIGITS);
    localparam int PW = cnt_bits(DIV);
    localparam int BW = cnt_bits(BLINK_FRAMES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic          POL       = (ACTIVE_LOW != 0);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic [4*DIGITS-1:0]   val_q, val_d;
    logic [DIGITS-1:0]     dpsh_q, dpsh_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  tick, wrap;
    logic [3:0]            nib;
    logic [6:0]            glyph;
    logic [DIGITS-1:0]     lz_blank, an_act;
    logic                  above_zero, sel_dp, sel_blink, sel_lz, blank;
    logic [6:0]            seg_l;
    logic                  dp_l;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        wrap    = tick && (idx_q == IDX_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
            end
        end
        frame_d = wrap;
        val_d   = load ? value : val_q;
        dpsh_d  = load ? dp_in : dpsh_q;
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        lz_blank   = '0;
        above_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above_zero  = above_zero && (val_q[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_en && (i > 0) && above_zero;
        end
        nib       = '0;
        sel_dp    = 1'b0;
        sel_blink = 1'b0;
        sel_lz    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib       = val_q[4*i +: 4];
                sel_dp    = dpsh_q[i];
                sel_blink = blink_en[i];
                sel_lz    = lz_blank[i];
            end
        end
        blank = (sel_blink && phase_q) || sel_lz;
    end

    seg_glyph u_glyph (
        .nib_i   (nib),
        .glyph_o (glyph)
    );

    always_comb begin
        an_act = '0;
        for (int i = 0; i < DIGITS; i++) an_act[i] = !blank && (idx_q == IW'(i));
        seg_l = blank ? SEG_OFF : glyph;
        dp_l  = blank ? 1'b1 : ~sel_dp;
        seg_d = POL ? seg_l : ~seg_l;
        dp_d  = POL ? dp_l : ~dp_l;
        an_d  = POL ? ~an_act : an_act;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            val_q   <= '0;
            dpsh_q  <= '0;
            seg_q   <= {7{POL}};
            dp_q    <= POL;
            an_q    <= {DIGITS{POL}};
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            val_q   <= val_d;
            dpsh_q  <= dpsh_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg    = seg_q;
    assign dp_out = dp_q;
    assign an     = an_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_s_seg_scan.sv
// Scoreboard bench for s_seg_scan: two instances (active-low DIV=4, active-high DIV=1).
module tb_s_seg_scan;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  blink_en = '0;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b, frame_a, frame_b;
    logic [3:0]  an_a, an_b;

    s_seg_scan #(.DIGITS(4), .DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .lz_en(lz_en), .blink_en(blink_en),
        .seg(seg_a), .dp_out(dp_a), .an(an_a), .frame(frame_a)
    );

    s_seg_scan #(.DIGITS(4), .DIV(1), .BLINK_FRAMES(3), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .lz_en(lz_en), .blink_en(blink_en),
        .seg(seg_b), .dp_out(dp_b), .an(an_b), .frame(frame_b)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n = 0;
    logic [15:0] sh_v = '0;
    logic [3:0]  sh_dp = '0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        ea, eb;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Expected outputs after edge n+1, given n edges since reset release.
    function automatic exp_t model(input int div, input int bf, input bit al, input int nn,
                                   input logic [15:0] sh, input logic [3:0] shdp,
                                   input logic lz, input logic [3:0] be);
        exp_t e;
        int   idx, ph;
        bit   blank;
        idx   = (nn / div) % 4;
        ph    = ((nn / (div * 4)) / bf) % 2;
        blank = (be[idx] && ph == 1) || (lz && idx > 0 && (sh >> (4 * idx)) == 16'h0);
        if (blank) begin
            e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF;
        end else begin
            e.seg = glyph(sh[4*idx +: 4]);
            e.dp  = ~shdp[idx];
            e.an  = ~(4'b0001 << idx);
        end
        e.frame = ((nn + 1) % (div * 4)) == 0;
        if (!al) begin
            e.seg = ~e.seg; e.dp = ~e.dp; e.an = ~e.an;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n = 0; sh_v = '0; sh_dp = '0;
        end else begin
            q_a.push_back(model(4, 2, 1'b1, n, sh_v, sh_dp, lz_en, blink_en));
            q_b.push_back(model(1, 3, 1'b0, n, sh_v, sh_dp, lz_en, blink_en));
            if (load) begin
                sh_v = value; sh_dp = dp_in;
            end
            n++;
        end
    end

    always @(posedge rst) begin
        q_a.delete();
        q_b.delete();
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (q_a.size() > 0) begin
                ea = q_a.pop_front();
                n_cmp++;
                if ({seg_a, dp_a, an_a, frame_a} !== ea) begin
                    n_bad++;
                    $display("FAIL dut_a n=%0d: got seg=%b dp=%b an=%b frame=%b, want seg=%b dp=%b an=%b frame=%b",
                             n, seg_a, dp_a, an_a, frame_a, ea.seg, ea.dp, ea.an, ea.frame);
                end
            end
            if (q_b.size() > 0) begin
                eb = q_b.pop_front();
                n_cmp++;
                if ({seg_b, dp_b, an_b, frame_b} !== eb) begin
                    n_bad++;
                    $display("FAIL dut_b n=%0d: got seg=%b dp=%b an=%b frame=%b, want seg=%b dp=%b an=%b frame=%b",
                             n, seg_b, dp_b, an_b, frame_b, eb.seg, eb.dp, eb.an, eb.frame);
                end
            end
            n_cmp++;
            if ($countones(~an_a) > 1 || $countones(an_b) > 1) begin
                n_bad++;
                $display("FAIL onehot: an_a=%b an_b=%b, want at most one active", an_a, an_b);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_seg_a",   32'(seg_a),   32'h7F);
        chk("rst_an_a",    32'(an_a),    32'hF);
        chk("rst_dp_a",    32'(dp_a),    32'h1);
        chk("rst_frame_a", 32'(frame_a), 32'h0);
        chk("rst_seg_b",   32'(seg_b),   32'h00);
        chk("rst_an_b",    32'(an_b),    32'h0);
        chk("rst_dp_b",    32'(dp_b),    32'h0);
        chk("rst_frame_b", 32'(frame_b), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(3);
        chk_reset();
        rst = 1'b0;
        step(10);
        rst = 1'b1;
        #1;
        chk_reset();
        step(2);
        rst = 1'b0;

        do_load(16'h12AF, 4'b0100);
        step(40);

        lz_en = 1'b1;
        do_load(16'h0030, 4'b0000);
        step(20);
        do_load(16'h0000, 4'b0000);
        step(20);
        lz_en = 1'b0;

        blink_en = 4'b0001;
        do_load(16'h8888, 4'b1111);
        step(140);
        blink_en = 4'b0000;

        do_load(16'h5A5A, 4'b0000);
        while (n % 4 != 3) step(1);
        do_load(16'hC3E7, 4'b1010);
        value = 16'hFFFF;
        dp_in = 4'b1111;
        step(20);

        repeat (600) begin
            value = 16'($urandom);
            dp_in = 4'($urandom);
            load  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 31) == 0) blink_en = 4'($urandom);
            step(1);
        end
        load = 1'b0;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
